// File: rtl/sync_fifo_pkg.sv
// Shared defaults and derived widths for the single-clock FIFO.
// Optional embedded checks in sync_fifo are enabled with SYNC_FIFO_ASSERTIONS_EN.
package sync_fifo_pkg;

  localparam int FIFO_WIDTH = 16;
  localparam int FIFO_DEPTH = 8;
  localparam int PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W      = PTR_W + 1;

  typedef logic [FIFO_WIDTH-1:0] data_t;

endpackage

// File: rtl/sync_fifo_if.sv
// Producer/consumer handshake bundle for sync_fifo.
// The master side drives requests and write data; the slave side is the FIFO.
interface sync_fifo_if
  import sync_fifo_pkg::*;
#(
  parameter int FIFO_WIDTH = sync_fifo_pkg::FIFO_WIDTH
);

  logic [FIFO_WIDTH-1:0] data_in;
  logic                  wr_en;
  logic                  rd_en;
  logic [FIFO_WIDTH-1:0] data_out;
  logic                  wr_ack;
  logic                  overflow;
  logic                  underflow;
  logic                  full;
  logic                  empty;
  logic                  almostfull;
  logic                  almostempty;

  modport master (
    output data_in, wr_en, rd_en,
    input  data_out, wr_ack, overflow, underflow,
    input  full, empty, almostfull, almostempty
  );

  modport slave (
    input  data_in, wr_en, rd_en,
    output data_out, wr_ack, overflow, underflow,
    output full, empty, almostfull, almostempty
  );

endinterface

// File: rtl/sync_fifo_mem.sv
// FIFO_DEPTH x FIFO_WIDTH storage with one write port and one registered read port.
// Only the read register is reset; the array itself keeps its contents.
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int FIFO_WIDTH = sync_fifo_pkg::FIFO_WIDTH,
  parameter int FIFO_DEPTH = sync_fifo_pkg::FIFO_DEPTH,
  parameter int PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [PTR_W-1:0]      waddr,
  input  logic [FIFO_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [PTR_W-1:0]      raddr,
  output logic [FIFO_WIDTH-1:0] rdata
);

  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // rdata holds its value whenever no read is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: pointers, occupancy count, status pulses and flags around sync_fifo_mem.
// Define SYNC_FIFO_ASSERTIONS_EN to compile the embedded consistency checks.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int FIFO_WIDTH = sync_fifo_pkg::FIFO_WIDTH,
  parameter int FIFO_DEPTH = sync_fifo_pkg::FIFO_DEPTH
) (
  input  logic       clk,
  input  logic       rst_n,
  sync_fifo_if.slave bus
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  full;
  logic                  empty;
  logic                  wr_ack;
  logic                  overflow;
  logic                  underflow;
  logic [FIFO_WIDTH-1:0] rdata;

  assign full   = (count == CNT_FULL);
  assign empty  = (count == '0);
  assign wr_acc = bus.wr_en && !full;
  assign rd_acc = bus.rd_en && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
    end else if (wr_acc) begin
      wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
    end else if (rd_acc) begin
      rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // A read request on an empty FIFO is not an underflow when a write arrives in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ack    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wr_ack    <= wr_acc;
      overflow  <= bus.wr_en && full;
      underflow <= bus.rd_en && empty && !bus.wr_en;
    end
  end

  sync_fifo_mem #(
    .FIFO_WIDTH (FIFO_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH),
    .PTR_W      (PTR_W)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata (bus.data_in),
    .re    (rd_acc),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  assign bus.data_out    = rdata;
  assign bus.wr_ack      = wr_ack;
  assign bus.overflow    = overflow;
  assign bus.underflow   = underflow;
  assign bus.full        = full;
  assign bus.empty       = empty;
  assign bus.almostfull  = (count == CNT_W'(FIFO_DEPTH - 1));
  assign bus.almostempty = (count == CNT_W'(1));

`ifdef SYNC_FIFO_ASSERTIONS_EN
  a_count_max: assert property (@(posedge clk) disable iff (!rst_n)
    count <= CNT_FULL)
    else $error("a_count_max");

  a_wr_ack: assert property (@(posedge clk) disable iff (!rst_n)
    wr_acc |=> bus.wr_ack)
    else $error("a_wr_ack");

  a_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    (bus.wr_en && full) |=> bus.overflow)
    else $error("a_overflow");

  a_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    (bus.rd_en && empty && !bus.wr_en) |=> bus.underflow)
    else $error("a_underflow");

  a_wr_wrap: assert property (@(posedge clk) disable iff (!rst_n)
    (wr_acc && wr_ptr == PTR_LAST) |=> (wr_ptr == '0))
    else $error("a_wr_wrap");

  a_rd_wrap: assert property (@(posedge clk) disable iff (!rst_n)
    (rd_acc && rd_ptr == PTR_LAST) |=> (rd_ptr == '0))
    else $error("a_rd_wrap");

  a_flags: assert property (@(posedge clk) disable iff (!rst_n)
    (bus.full == (count == CNT_FULL)) && (bus.empty == (count == '0)) &&
    (bus.almostfull == (count == CNT_W'(FIFO_DEPTH - 1))) &&
    (bus.almostempty == (count == CNT_W'(1))))
    else $error("a_flags");
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo (16 x 8): vector table plus hand-written reset and streaming sequences.
module tb_sync_fifo;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  sync_fifo_if #(.FIFO_WIDTH(16)) bus ();

  sync_fifo #(.FIFO_WIDTH(16), .FIFO_DEPTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // flags are {wr_ack, overflow, underflow, full, empty, almostfull, almostempty}
  typedef struct {
    logic        wr;
    logic        rd;
    logic [15:0] din;
    logic [15:0] dout;
    logic [6:0]  flg;
  } vec_t;

  vec_t vecs[22];

  function automatic logic [22:0] obs();
    return {bus.data_out, bus.wr_ack, bus.overflow, bus.underflow,
            bus.full, bus.empty, bus.almostfull, bus.almostempty};
  endfunction

  task automatic chk(input string name, input logic [15:0] dout, input logic [6:0] flg);
    logic [22:0] got;
    got = obs();
    checks++;
    if (got !== {dout, flg}) begin
      errors++;
      $display("FAIL %s: data_out=%h flags=%b, expected data_out=%h flags=%b",
               name, got[22:7], got[6:0], dout, flg);
    end
  endtask

  task automatic step(input logic w, input logic r, input logic [15:0] d);
    @(negedge clk);
    bus.wr_en   = w;
    bus.rd_en   = r;
    bus.data_in = d;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(logic w, logic r, logic [15:0] d, logic [15:0] q, logic [6:0] f);
    vec_t v;
    v.wr = w; v.rd = r; v.din = d; v.dout = q; v.flg = f;
    return v;
  endfunction

  initial begin
    bus.wr_en   = 1'b0;
    bus.rd_en   = 1'b0;
    bus.data_in = '0;

    vecs[0]  = mk(0, 1, 16'h0000, 16'h0000, 7'b0010100);
    vecs[1]  = mk(1, 1, 16'h00AA, 16'h0000, 7'b1000001);
    vecs[2]  = mk(0, 1, 16'h0000, 16'h00AA, 7'b0000100);
    vecs[3]  = mk(1, 0, 16'h0001, 16'h00AA, 7'b1000001);
    for (int i = 4; i <= 8; i++)
      vecs[i] = mk(1, 0, 16'(i - 2), 16'h00AA, 7'b1000000);
    vecs[9]  = mk(1, 0, 16'h0007, 16'h00AA, 7'b1000010);
    vecs[10] = mk(1, 0, 16'h0008, 16'h00AA, 7'b1001000);
    vecs[11] = mk(1, 0, 16'hDEAD, 16'h00AA, 7'b0101000);
    vecs[12] = mk(1, 1, 16'hBEEF, 16'h0001, 7'b0100010);
    for (int i = 13; i <= 17; i++)
      vecs[i] = mk(0, 1, 16'h0000, 16'(i - 11), 7'b0000000);
    vecs[18] = mk(0, 1, 16'h0000, 16'h0007, 7'b0000001);
    vecs[19] = mk(0, 1, 16'h0000, 16'h0008, 7'b0000100);
    vecs[20] = mk(0, 1, 16'h0000, 16'h0008, 7'b0010100);
    vecs[21] = mk(0, 0, 16'h0000, 16'h0008, 7'b0000100);

    #2;
    chk("reset_state", 16'h0000, 7'b0000100);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 22; i++) begin
      step(vecs[i].wr, vecs[i].rd, vecs[i].din);
      chk($sformatf("vec%0d", i), vecs[i].dout, vecs[i].flg);
    end

    // four entries in flight, then a long simultaneous read/write stream across several wraps
    for (int k = 0; k < 4; k++) begin
      step(1, 0, 16'h0100 + 16'(k));
      chk($sformatf("fill4_%0d", k), 16'h0008, (k == 0) ? 7'b1000001 : 7'b1000000);
    end
    for (int i = 0; i < 20; i++) begin
      step(1, 1, 16'h0104 + 16'(i));
      chk($sformatf("stream%0d", i), 16'h0100 + 16'(i), 7'b1000000);
    end
    for (int j = 0; j < 4; j++) begin
      step(0, 1, 16'h0000);
      chk($sformatf("drain%0d", j), 16'h0114 + 16'(j),
          (j == 3) ? 7'b0000100 : (j == 2) ? 7'b0000001 : 7'b0000000);
    end

    // reset in the middle of a write burst with data already buffered
    step(1, 0, 16'h5555);
    chk("pre_rst_wr0", 16'h0117, 7'b1000001);
    step(1, 0, 16'h6666);
    chk("pre_rst_wr1", 16'h0117, 7'b1000000);
    @(negedge clk);
    bus.wr_en   = 1'b1;
    bus.data_in = 16'h7777;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async", 16'h0000, 7'b0000100);
    @(posedge clk);
    #1;
    chk("rst_held", 16'h0000, 7'b0000100);
    @(negedge clk);
    bus.wr_en = 1'b0;
    rst_n     = 1'b1;
    step(1, 0, 16'h1234);
    chk("post_rst_wr", 16'h0000, 7'b1000001);
    step(0, 1, 16'h0000);
    chk("post_rst_rd", 16'h1234, 7'b0000100);
    step(0, 0, 16'h0000);
    chk("post_rst_idle", 16'h1234, 7'b0000100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
